// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard.
package reg_scoreboard_pkg;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NUM_SRC = 2;

  function automatic int nreg_f(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/reg_scoreboard_onehot_decoder.sv
// Binary address to enable-gated one-hot vector.
module onehot_decoder import reg_scoreboard_pkg::*; #(
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int NREG   = nreg_f(ADDR_W)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NREG-1:0]   onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register busy-bit scoreboard: WAW stall on issue, RAW hazard query per source
// port, writeback clear with same-cycle bypass, flush and sticky clear-error.
module reg_scoreboard import reg_scoreboard_pkg::*; #(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int NUM_SRC  = DEF_NUM_SRC,
  parameter  int ZERO_REG = 1,
  localparam int NREG     = nreg_f(ADDR_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      set_valid,
  input  logic [ADDR_W-1:0]         set_addr,
  output logic                      set_ready,
  input  logic                      clr_valid,
  input  logic [ADDR_W-1:0]         clr_addr,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  output logic [NUM_SRC-1:0]        src_busy,
  output logic [NREG-1:0]           busy_vec,
  output logic [ADDR_W:0]           busy_count,
  output logic                      clr_err
);
  // Register 0 never enters the tracked set when it is hardwired.
  localparam logic [NREG-1:0] TRACK_MASK =
    (ZERO_REG != 0) ? {{(NREG-1){1'b1}}, 1'b0} : {NREG{1'b1}};

  logic [NREG-1:0] busy_q, busy_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [NREG-1:0] set_oh, clr_oh;
  logic            set_fire, clr_bypass, zero_clr, clr_miss;

  assign clr_bypass = clr_valid && (clr_addr == set_addr);
  assign set_ready  = !flush && (!busy_q[set_addr] || clr_bypass);
  assign set_fire   = set_valid && set_ready;

  onehot_decoder #(.ADDR_W(ADDR_W)) u_set_dec (
    .addr_i   (set_addr),
    .en_i     (set_fire),
    .onehot_o (set_oh)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_clr_dec (
    .addr_i   (clr_addr),
    .en_i     (clr_valid),
    .onehot_o (clr_oh)
  );

  assign zero_clr = (ZERO_REG != 0) && (clr_addr == '0);
  assign clr_miss = clr_valid && !busy_q[clr_addr] && !zero_clr;

  always_comb begin
    busy_d = ((busy_q & ~clr_oh) | set_oh) & TRACK_MASK;
    err_d  = err_q | clr_miss;
    if (flush) begin
      busy_d = '0;
      err_d  = err_q;
    end
  end

  // Count the next-state vector so busy_count moves in step with busy_vec.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // A writeback in flight this cycle already resolves the hazard.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [ADDR_W-1:0] a;
    assign a           = src_addr[k*ADDR_W +: ADDR_W];
    assign src_busy[k] = busy_q[a] && !(clr_valid && (clr_addr == a));
  end

  assign busy_vec   = busy_q;
  assign busy_count = cnt_q;
  assign clr_err    = err_q;
endmodule
